// File: rtl/clk_pkg.sv
// ============================================================================
// Module : clk_pkg
// Brief  : Shared definitions for the clock-project counters: mode encoding,
//          button FSM states and default timing for a 50 MHz system clock.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_pkg;

    // Mode switch encoding
    localparam logic MODE_RUN = 1'b0;
    localparam logic MODE_SET = 1'b1;

    // Default button timing at 50 MHz: 10 ms debounce, 0.5 s delay, 0.1 s rate
    localparam int DEFAULT_DEBOUNCE     = 500000;
    localparam int DEFAULT_REPEAT_DELAY = 25000000;
    localparam int DEFAULT_REPEAT_RATE  = 5000000;

    // Button press/hold/repeat FSM states
    typedef enum logic [2:0] {
        BTN_IDLE        = 3'd0,
        BTN_DEB_PRESS   = 3'd1,
        BTN_HELD        = 3'd2,
        BTN_REPEAT      = 3'd3,
        BTN_DEB_RELEASE = 3'd4
    } btn_state_t;

    // Largest of three timing values, used to size shared counters
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin_to_bcd.sv
// ============================================================================
// Module : bin_to_bcd
// Brief  : Combinational binary to packed-BCD converter (shift-and-add-3),
//          DIGITS decimal digits, digit 0 in the LSBs.
// Rev    : 2.0 - generalised to DIGITS digits
// ============================================================================
`default_nettype none

module bin_to_bcd #(
    parameter int WIDTH  = 6,
    parameter int DIGITS = 2
) (
    input  logic [WIDTH-1:0]    i_bin,
    output logic [4*DIGITS-1:0] o_bcd
);

    localparam int c_SW = WIDTH + 4 * DIGITS;

    logic [c_SW-1:0] w_scratch;

    // Double-dabble: correct each BCD nibble >= 5 before every shift
    always_comb begin
        w_scratch              = '0;
        w_scratch[WIDTH-1:0]   = i_bin;
        for (int i = 0; i < WIDTH; i++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (w_scratch[WIDTH + 4*d +: 4] >= 4'd5) begin
                    w_scratch[WIDTH + 4*d +: 4] = w_scratch[WIDTH + 4*d +: 4] + 4'd3;
                end
            end
            w_scratch = w_scratch << 1;
        end
        o_bcd = w_scratch[WIDTH +: 4*DIGITS];
    end

endmodule

`default_nettype wire

// File: rtl/btn_step.sv
// ============================================================================
// Module : btn_step
// Brief  : Active-low button conditioner: 2-flop synchronizer, debounce and
//          hold/auto-repeat FSM producing one-cycle step pulses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_step
    import clk_pkg::*;
#(
    parameter int DEBOUNCE     = DEFAULT_DEBOUNCE,
    parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    input  logic i_enable,
    output logic o_step
);

    localparam int c_MAX = max3(DEBOUNCE, REPEAT_DELAY, REPEAT_RATE);
    localparam int c_CW  = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CW-1:0] c_DEB_LAST  = c_CW'(DEBOUNCE - 1);
    localparam logic [c_CW-1:0] c_DLY_LAST  = c_CW'(REPEAT_DELAY - 1);
    localparam logic [c_CW-1:0] c_RATE_LAST = c_CW'(REPEAT_RATE - 1);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    logic [1:0]      r_sync;
    logic            r_prev;
    btn_state_t      r_state;
    btn_state_t      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            r_from_repeat;
    logic            w_from_repeat_nxt;
    logic            r_step;
    logic            w_step_nxt;
    logic            w_pressed;
    logic            w_fall;

    // Only a fresh press starts a sequence, so a button held through reset or
    // a mode change must be released before it can step again.
    assign w_pressed = ~r_sync[1];
    assign w_fall    = r_prev & ~r_sync[1];
    assign o_step    = r_step;

    // Synchronize the button; reset preloads the current level so no edge is seen
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {2{i_btn_n}};
            r_prev <= i_btn_n;
        end else begin
            r_sync <= {r_sync[0], i_btn_n};
            r_prev <= r_sync[1];
        end
    end

    // State, counter and step pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BTN_IDLE;
            r_cnt         <= '0;
            r_from_repeat <= 1'b0;
            r_step        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_from_repeat <= w_from_repeat_nxt;
            r_step        <= w_step_nxt;
        end
    end

    // Next-state logic: debounce press, hold delay, repeat, debounce release
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_from_repeat_nxt = r_from_repeat;
        w_step_nxt        = 1'b0;
        if (!i_enable) begin
            w_state_nxt       = BTN_IDLE;
            w_cnt_nxt         = '0;
            w_from_repeat_nxt = 1'b0;
        end else begin
            case (r_state)
                BTN_IDLE: begin
                    if (w_fall) begin
                        if (c_DEB_LAST == '0) begin
                            w_state_nxt = BTN_HELD;
                            w_cnt_nxt   = '0;
                            w_step_nxt  = 1'b1;
                        end else begin
                            // This sample is the first of the debounce window
                            w_state_nxt = BTN_DEB_PRESS;
                            w_cnt_nxt   = c_ONE;
                        end
                    end
                end
                BTN_DEB_PRESS: begin
                    if (!w_pressed) begin
                        w_state_nxt = BTN_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        w_state_nxt = BTN_HELD;
                        w_cnt_nxt   = '0;
                        w_step_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
                BTN_HELD, BTN_REPEAT: begin
                    if (!w_pressed) begin
                        w_from_repeat_nxt = (r_state == BTN_REPEAT);
                        if (c_DEB_LAST == '0) begin
                            w_state_nxt = BTN_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = BTN_DEB_RELEASE;
                            w_cnt_nxt   = c_ONE;
                        end
                    end else if (r_cnt == ((r_state == BTN_HELD) ? c_DLY_LAST : c_RATE_LAST)) begin
                        w_state_nxt = BTN_REPEAT;
                        w_cnt_nxt   = '0;
                        w_step_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
                BTN_DEB_RELEASE: begin
                    if (w_pressed) begin
                        // Release was a bounce: resume holding without a step
                        w_state_nxt = r_from_repeat ? BTN_REPEAT : BTN_HELD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        w_state_nxt = BTN_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_ONE;
                    end
                end
                default: begin
                    w_state_nxt = BTN_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/led7_decoder.sv
// ============================================================================
// Module : led7_decoder
// Brief  : BCD digit to active-high 7-segment pattern {g,f,e,d,c,b,a};
//          non-decimal codes blank the digit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led7_decoder (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Segment lookup
    always_comb begin
        o_seg = 7'h00;
        case (i_bcd)
            4'd0: o_seg = 7'h3F;
            4'd1: o_seg = 7'h06;
            4'd2: o_seg = 7'h5B;
            4'd3: o_seg = 7'h4F;
            4'd4: o_seg = 7'h66;
            4'd5: o_seg = 7'h6D;
            4'd6: o_seg = 7'h7D;
            4'd7: o_seg = 7'h07;
            4'd8: o_seg = 7'h7F;
            4'd9: o_seg = 7'h6F;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mod_set_counter.sv
// ============================================================================
// Module : mod_set_counter
// Brief  : Modulo-MODULUS counter stepped by tick_in edges in run mode and by
//          debounced auto-repeat buttons in set mode; BCD and 7-seg outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_set_counter
    import clk_pkg::*;
#(
    parameter int MODULUS      = 60,
    parameter int WIDTH        = 6,
    parameter int DIGITS       = 2,
    parameter int RUN_DOWN     = 0,
    parameter int DEBOUNCE     = DEFAULT_DEBOUNCE,
    parameter int REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEFAULT_REPEAT_RATE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_in,
    input  logic                mode,
    input  logic                add_n,
    input  logic                deduct_n,
    output logic [WIDTH-1:0]    value,
    output logic                carry_out,
    output logic [4*DIGITS-1:0] bcd,
    output logic [7*DIGITS-1:0] seg
);

    localparam logic [WIDTH-1:0] c_TOP = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [1:0]       r_tick_sync;
    logic             r_tick_prev;
    logic             r_mode_q;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_value_nxt;
    logic             r_carry;
    logic             w_carry_nxt;
    logic             w_tick_rise;
    logic             w_btn_en;
    logic             w_add_step;
    logic             w_ded_step;

    assign w_tick_rise = r_tick_sync[1] & ~r_tick_prev;
    // Buttons only run in set mode and are flushed on the cycle mode changes
    assign w_btn_en    = (mode == MODE_SET) && (mode == r_mode_q);
    assign value       = r_value;
    assign carry_out   = r_carry;

    // Tick synchronizer/edge tracker and mode history; runs in both modes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_sync <= {2{tick_in}};
            r_tick_prev <= tick_in;
            r_mode_q    <= mode;
        end else begin
            r_tick_sync <= {r_tick_sync[0], tick_in};
            r_tick_prev <= r_tick_sync[1];
            r_mode_q    <= mode;
        end
    end

    btn_step #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_btn_add (
        .clk      (clk),
        .rst      (reset),
        .i_btn_n  (add_n),
        .i_enable (w_btn_en),
        .o_step   (w_add_step)
    );

    btn_step #(
        .DEBOUNCE     (DEBOUNCE),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_btn_deduct (
        .clk      (clk),
        .rst      (reset),
        .i_btn_n  (deduct_n),
        .i_enable (w_btn_en),
        .o_step   (w_ded_step)
    );

    // Next count: explicit wrap compares, since MODULUS need not be 2^WIDTH
    always_comb begin
        w_value_nxt = r_value;
        w_carry_nxt = 1'b0;
        if (mode == MODE_RUN) begin
            if (w_tick_rise) begin
                if (RUN_DOWN == 0) begin
                    if (r_value == c_TOP) begin
                        w_value_nxt = '0;
                        w_carry_nxt = 1'b1;
                    end else begin
                        w_value_nxt = r_value + c_ONE;
                    end
                end else begin
                    if (r_value == '0) begin
                        w_value_nxt = c_TOP;
                        w_carry_nxt = 1'b1;
                    end else begin
                        w_value_nxt = r_value - c_ONE;
                    end
                end
            end
        end else if (w_add_step != w_ded_step) begin
            // Coincident add and deduct steps cancel out
            if (w_add_step) begin
                w_value_nxt = (r_value == c_TOP) ? '0 : (r_value + c_ONE);
            end else begin
                w_value_nxt = (r_value == '0) ? c_TOP : (r_value - c_ONE);
            end
        end
    end

    // Registered count and wrap carry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_carry <= 1'b0;
        end else begin
            r_value <= w_value_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    bin_to_bcd #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bcd (
        .i_bin (r_value),
        .o_bcd (bcd)
    );

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        led7_decoder u_led7 (
            .i_bcd (bcd[4*g +: 4]),
            .o_seg (seg[7*g +: 7])
        );
    end

endmodule

`default_nettype wire
